// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// Used by the unit itself, its bus interface, the decoder and stall control.
package muldiv_pkg;

  localparam int MULDIV_XLEN = 32;
  // Edges from the start edge to the end of the done cycle.
  localparam int MULDIV_LAT  = MULDIV_XLEN + 2;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between execute control and muldiv_unit.
//   master (control): drives start, funct3, opA, opB, rd_in, kill;
//                     observes busy, done, result, rd_out.
//   slave  (unit):    the reverse directions.
interface muldiv_if #(
  parameter int XLEN = 32
) ();

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [4:0]      rd_in;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, opA, opB, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, opA, opB, rd_in, kill,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed latency for every op.
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : muldiv_if.slave -- start/funct3/opA/opB/rd_in/kill in,
//            busy/done/result/rd_out out
// Operands are reduced to magnitudes at start; the core loop is purely
// unsigned (shift-add or restoring shift-subtract), and the sign is put
// back in FIX.
//
// state | meaning
// IDLE  | waiting for start; operands are sampled on the accepting edge
// CALC  | XLEN iteration steps, one per cycle, counted down to zero
// FIX   | sign correction, special cases, hi/lo select; result written
// DONE  | done pulse for write-back, then back to IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic     CLK,
  input  logic     RST_N,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  muldiv_state_t state, state_nxt;
  logic          start_acc;

  // captured request
  muldiv_op_t    op_q;
  logic [4:0]    rd_q;
  logic          neg_q;
  logic          bzero_q;

  // shared shift pair: acc = product hi / partial remainder,
  // lo = multiplier then product lo / dividend then quotient
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opnd;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  // sign/abs pre-stage
  muldiv_op_t      op_in;
  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b, neg_in;
  logic [XLEN-1:0] abs_a, abs_b;

  // one iteration step
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;

  // fix-up
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_mag;
  logic [XLEN-1:0]   fix_val;

  assign start_acc = (state == IDLE) && bus.start && !bus.kill;

  always_comb begin
    op_in = muldiv_op_t'(bus.funct3);
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      OP_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
    neg_a  = sgn_a & bus.opA[XLEN-1];
    neg_b  = sgn_b & bus.opB[XLEN-1];
    abs_a  = neg_a ? -bus.opA : bus.opA;
    abs_b  = neg_b ? -bus.opB : bus.opB;
    // remainder takes the dividend's sign, everything else the product sign
    neg_in = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
  end

  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // no borrow out means the trial subtraction fits
    div_ok    = ~div_diff[XLEN];
  end

  // Divide overflow (most-negative / -1) needs no special path: the
  // magnitude quotient 2^(XLEN-1) negates to itself and the remainder is 0.
  // Remainder by zero also falls out naturally: with a zero divisor every
  // trial subtraction succeeds, so acc ends up holding |opA|, and the
  // dividend sign restores opA.
  always_comb begin
    prod    = {acc, lo};
    prod_s  = neg_q ? -prod : prod;
    div_mag = op_is_rem(op_q) ? acc : lo;
    fix_val = '0;
    if (op_is_div(op_q)) begin
      if (bzero_q && !op_is_rem(op_q)) fix_val = '1;
      else                              fix_val = neg_q ? -div_mag : div_mag;
    end else if (op_q == OP_MUL) begin
      fix_val = prod_s[XLEN-1:0];
    end else begin
      fix_val = prod_s[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_acc) state_nxt = CALC;
      CALC: begin
        if (bus.kill)        state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX:  state_nxt = bus.kill ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_acc) begin
            op_q    <= op_in;
            rd_q    <= bus.rd_in;
            neg_q   <= neg_in;
            bzero_q <= (bus.opB == '0);
            cnt     <= CNT_W'(XLEN - 1);
            acc     <= '0;
            if (op_is_div(op_in)) begin
              lo   <= abs_a;
              opnd <= abs_b;
            end else begin
              lo   <= abs_b;
              opnd <= abs_a;
            end
          end
        end
        CALC: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (op_is_div(op_q)) begin
            acc <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo  <= {lo[XLEN-2:0], div_ok};
          end else begin
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        FIX: begin
          if (!bus.kill) begin
            result_q <= fix_val;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed corner cases, control scenarios and randomized
// ops against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = MULDIV_XLEN;
  // done is visible in the cycle after edge E+XLEN+1, E being the start edge
  localparam int DONE_EDGES = XLEN + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    int         qi;
    logic       ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    qi  = 0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        qi = $signed(a) / $signed(b);
        return qi;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        qi = $signed(a) % $signed(b);
        return qi;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.opA    = a;
    bus.opB    = b;
    bus.rd_in  = rd;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom_range(0, 7));
    bus.opA    = $urandom;
    bus.opB    = $urandom;
    bus.rd_in  = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int edges;
    issue(f3, a, b, rd);
    wait_done(edges);
    chk({tag, "_lat"}, 64'(edges), 64'(DONE_EDGES));
    chk({tag, "_res"}, 64'(bus.result), 64'(exp));
    chk({tag, "_rd"},  64'(bus.rd_out), 64'(rd));
    @(negedge clk);
    chk({tag, "_pulse"}, {62'h0, bus.done, bus.busy}, 64'h0);
  endtask

  initial begin
    int edges, ndone, first_at;
    logic [31:0] ra, rb, old_res;
    logic [2:0]  rf;
    logic [4:0]  old_rd;

    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = 3'd0;
    bus.opA    = '0;
    bus.opB    = '0;
    bus.rd_in  = '0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   64'(bus.busy),   64'h0);
    chk("rst_done",   64'(bus.done),   64'h0);
    chk("rst_result", 64'(bus.result), 64'h0);
    chk("rst_rd",     64'(bus.rd_out), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed arithmetic, expected values written out by hand
    run_op("mul_7_m3",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB);
    run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000);
    run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE);
    run_op("mulhsu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF);
    run_op("divu_100_7",  3'd5, 32'd100,       32'd7,         5'd7,  32'd14);
    run_op("remu_100_7",  3'd7, 32'd100,       32'd7,         5'd8,  32'd2);
    run_op("div_x_0",     3'd4, 32'd12345,     32'd0,         5'd9,  32'hFFFF_FFFF);
    run_op("div_neg_0",   3'd4, 32'hFFFF_FFF9, 32'd0,         5'd10, 32'hFFFF_FFFF);
    run_op("divu_x_0",    3'd5, 32'hDEAD_BEEF, 32'd0,         5'd11, 32'hFFFF_FFFF);
    run_op("remu_5_0",    3'd7, 32'd5,         32'd0,         5'd12, 32'd5);
    run_op("rem_neg_0",   3'd6, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFF9);
    run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0);
    run_op("divu_min_m1", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0);

    // start held high through a whole op: exactly one done, then re-accept
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.opA    = 32'd3;
    bus.opB    = 32'd5;
    bus.rd_in  = 5'd17;
    @(posedge clk);
    @(negedge clk);
    ndone    = 0;
    first_at = 0;
    for (int k = 1; k <= DONE_EDGES + 1; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        first_at = k;
      end
    end
    chk("hold_ndone",    64'(ndone),    64'd1);
    chk("hold_done_at",  64'(first_at), 64'(DONE_EDGES));
    chk("hold_idle",     64'(bus.busy), 64'h0);
    @(negedge clk);
    chk("hold_reaccept", 64'(bus.busy), 64'h1);
    bus.start = 1'b0;
    bus.opA   = 32'd6;
    wait_done(edges);
    chk("hold2_lat", 64'(edges),      64'(DONE_EDGES));
    chk("hold2_res", 64'(bus.result), 64'd15);
    chk("hold2_rd",  64'(bus.rd_out), 64'd17);
    @(negedge clk);

    // kill at CALC step 10
    old_res = bus.result;
    old_rd  = bus.rd_out;
    issue(3'd5, 32'd1000, 32'd3, 5'd20);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_busy", 64'(bus.busy), 64'h0);
    chk("kill_done", 64'(bus.done), 64'h0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("kill_ndone",  64'(ndone),      64'h0);
    chk("kill_result", 64'(bus.result), 64'(old_res));
    chk("kill_rd",     64'(bus.rd_out), 64'(old_rd));

    // kill and start together in IDLE: start dropped
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("killstart_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);

    // kill during DONE: that cycle's pulse still shows
    issue(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd21);
    wait_done(edges);
    bus.kill = 1'b1;
    #1;
    chk("killdone_pulse", 64'(bus.done),   64'h1);
    chk("killdone_res",   64'(bus.result), 64'h1);
    @(negedge clk);
    bus.kill = 1'b0;
    chk("killdone_idle",  64'(bus.busy),   64'h0);

    // asynchronous reset mid-CALC
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   64'(bus.busy),   64'h0);
    chk("arst_done",   64'(bus.done),   64'h0);
    chk("arst_result", 64'(bus.result), 64'h0);
    chk("arst_rd",     64'(bus.rd_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op("after_rst", 3'd0, 32'd9, 32'd9, 5'd23, 32'd81);

    // randomized ops against the reference model, issued back to back
    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, 5'($urandom_range(0, 31)),
             ref_calc(rf, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
